// File: rtl/decoder_nx2n_scan.sv
// rtl/decoder_nx2n_scan.sv - registered N-to-2**N one-hot decoder with direct and auto-scan modes
module decoder_nx2n_scan #(
  parameter int N    = 3,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  output logic [(2**N)-1:0] y,
  output logic [N-1:0]      idx,
  output logic              active,
  output logic              wrap
);

  localparam int W  = 2**N;
  // Wide enough to hold HOLD itself, so the counter can never wrap on its own.
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N-1:0]  IDX_LAST  = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    y_q, y_d;
  logic [N-1:0]    idx_q, idx_d;
  logic            active_q, active_d;
  logic            wrap_q, wrap_d;
  logic [HW-1:0]   hold_q, hold_d;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= '0;
      idx_q    <= '0;
      active_q <= 1'b0;
      wrap_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      wrap_q   <= wrap_d;
      hold_q   <= hold_d;
    end
  end

  // Next state, index and hold count; y is always derived from the single next index.
  always_comb begin
    state_d  = IDLE;
    idx_d    = '0;
    hold_d   = '0;
    wrap_d   = 1'b0;
    active_d = 1'b0;
    y_d      = '0;

    if (!en) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d  = DIRECT;
      idx_d    = sel;
      active_d = 1'b1;
    end else if (state_q != SCAN) begin
      // Entering scan always starts from the present sel with a fresh hold period.
      state_d  = SCAN;
      idx_d    = sel;
      active_d = 1'b1;
    end else begin
      state_d  = SCAN;
      active_d = 1'b1;
      if (hold_q == HOLD_LAST) begin
        hold_d = '0;
        idx_d  = idx_q + N'(1);
        wrap_d = (idx_q == IDX_LAST);
      end else begin
        hold_d = hold_q + HW'(1);
        idx_d  = idx_q;
      end
    end

    if (active_d) begin
      y_d = W'(1) << idx_d;
    end
  end

  assign y      = y_q;
  assign idx    = idx_q;
  assign active = active_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// tb/tb_decoder_nx2n_scan.sv - bench for decoder_nx2n_scan with HOLD=4 and HOLD=1 instances
module tb_decoder_nx2n_scan;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic [2:0] sel;
  logic [7:0] y_a, y_b;
  logic [2:0] idx_a, idx_b;
  logic       active_a, active_b;
  logic       wrap_a, wrap_b;

  int tests;
  int failed;

  decoder_nx2n_scan #(.N(3), .HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(y_a), .idx(idx_a), .active(active_a), .wrap(wrap_a)
  );

  decoder_nx2n_scan #(.N(3), .HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(y_b), .idx(idx_b), .active(active_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 direct, 2 scan. In scan the index is the
  // start index plus whole hold periods elapsed, modulo 8.
  int m_st[2];
  int m_start[2];
  int m_el[2];
  int m_dsel[2];
  int hv[2] = '{4, 1};

  typedef struct {
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] y;
    logic [2:0] idx;
    logic       act;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_el[k] = 0; m_start[k] = 0; m_dsel[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst || !en) begin
        m_st[k] = 0; m_el[k] = 0;
      end else if (!mode) begin
        m_st[k] = 1; m_dsel[k] = int'(sel);
      end else if (m_st[k] != 2) begin
        m_st[k] = 2; m_start[k] = int'(sel); m_el[k] = 0;
      end else begin
        m_el[k]++;
      end
    end
  endtask

  function automatic int m_idx(input int k);
    if (m_st[k] == 0) return 0;
    if (m_st[k] == 1) return m_dsel[k];
    return (m_start[k] + m_el[k] / hv[k]) % 8;
  endfunction

  function automatic int m_wrap(input int k);
    if (m_st[k] != 2) return 0;
    return (m_el[k] > 0 && (m_el[k] % hv[k]) == 0 && m_idx(k) == 0) ? 1 : 0;
  endfunction

  task automatic check_model();
    int ei, ea;
    for (int k = 0; k < 2; k++) begin
      ei = m_idx(k);
      ea = (m_st[k] != 0) ? 1 : 0;
      if (k == 0) begin
        chk("model_a_y", int'(y_a), ea ? (1 << ei) : 0);
        chk("model_a_idx", int'(idx_a), ei);
        chk("model_a_active", int'(active_a), ea);
        chk("model_a_wrap", int'(wrap_a), m_wrap(0));
        chk("onehot_a", ($countones(y_a) <= 1) ? 1 : 0, 1);
      end else begin
        chk("model_b_y", int'(y_b), ea ? (1 << ei) : 0);
        chk("model_b_idx", int'(idx_b), ei);
        chk("model_b_active", int'(active_b), ea);
        chk("model_b_wrap", int'(wrap_b), m_wrap(1));
        chk("onehot_b", ($countones(y_b) <= 1) ? 1 : 0, 1);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int e;
    tests  = 0;
    failed = 0;

    vt[0] = '{1'b1, 1'b0, 3'd0, 8'h01, 3'd0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 3'd1, 8'h02, 3'd1, 1'b1};
    vt[2] = '{1'b1, 1'b0, 3'd2, 8'h04, 3'd2, 1'b1};
    vt[3] = '{1'b1, 1'b0, 3'd3, 8'h08, 3'd3, 1'b1};
    vt[4] = '{1'b1, 1'b0, 3'd4, 8'h10, 3'd4, 1'b1};
    vt[5] = '{1'b1, 1'b0, 3'd5, 8'h20, 3'd5, 1'b1};
    vt[6] = '{1'b1, 1'b0, 3'd6, 8'h40, 3'd6, 1'b1};
    vt[7] = '{1'b1, 1'b0, 3'd7, 8'h80, 3'd7, 1'b1};
    vt[8] = '{1'b0, 1'b0, 3'd5, 8'h00, 3'd0, 1'b0};
    vt[9] = '{1'b1, 1'b0, 3'd3, 8'h08, 3'd3, 1'b1};

    // Reset state, visible without any clock edge.
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0;
    model_reset();
    #2;
    chk("reset_y", int'(y_a), 0);
    chk("reset_idx", int'(idx_a), 0);
    chk("reset_active", int'(active_a), 0);
    chk("reset_wrap", int'(wrap_a), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First edge after release must take effect.
    en = 1'b1; mode = 1'b0; sel = 3'd4;
    tick();
    chk("first_edge_y", int'(y_a), 8'h10);

    // Direct sweep and enable gating from the vector table.
    for (int i = 0; i < 10; i++) begin
      en = vt[i].en; mode = vt[i].mode; sel = vt[i].sel;
      tick();
      chk($sformatf("vec%0d_y", i), int'(y_a), int'(vt[i].y));
      chk($sformatf("vec%0d_idx", i), int'(idx_a), int'(vt[i].idx));
      chk($sformatf("vec%0d_active", i), int'(active_a), int'(vt[i].act));
    end

    // Scan wrap from 6 with HOLD=4; sel changes mid-scan are ignored.
    en = 1'b0; tick();
    en = 1'b1; mode = 1'b1; sel = 3'd6;
    for (int c = 0; c <= 32; c++) begin
      if (c == 20) sel = 3'd1;
      tick();
      if (c <= 12) begin
        e = (c < 4) ? 6 : (c < 8) ? 7 : (c < 12) ? 0 : 1;
        chk($sformatf("scan_idx_c%0d", c), int'(idx_a), e);
        chk($sformatf("scan_wrap_c%0d", c), int'(wrap_a), (c == 8) ? 1 : 0);
      end
      if (c == 32) chk("scan_loop32_idx", int'(idx_a), 6);
    end

    // HOLD=1 scan from 0 advances every cycle.
    en = 1'b0; tick();
    en = 1'b1; mode = 1'b1; sel = 3'd0;
    for (int c = 0; c <= 8; c++) begin
      tick();
      chk($sformatf("hold1_idx_c%0d", c), int'(idx_b), c % 8);
      chk($sformatf("hold1_wrap_c%0d", c), int'(wrap_b), (c == 8) ? 1 : 0);
    end

    // Mode switch at idx 3, then restart scan from the new sel.
    en = 1'b0; tick();
    en = 1'b1; mode = 1'b1; sel = 3'd0;
    for (int c = 0; c < 13; c++) tick();
    chk("switch_pre_idx", int'(idx_a), 3);
    mode = 1'b0; sel = 3'd5;
    tick();
    chk("switch_y", int'(y_a), 8'h20);
    chk("switch_wrap", int'(wrap_a), 0);
    mode = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("restart_idx_c%0d", c), int'(idx_a), (c < 4) ? 5 : 6);
    end

    // Enable drop during scan.
    en = 1'b0;
    tick();
    chk("endrop_y", int'(y_a), 0);
    chk("endrop_active", int'(active_a), 0);
    chk("endrop_idx", int'(idx_a), 0);

    // Asynchronous reset mid-cycle during scan.
    en = 1'b1; mode = 1'b1; sel = 3'd1;
    for (int c = 0; c < 6; c++) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("async_y", int'(y_a), 0);
    chk("async_idx", int'(idx_a), 0);
    chk("async_active", int'(active_a), 0);
    model_reset();
    #2;
    rst = 1'b0;
    sel = 3'd2;
    tick();
    chk("async_restart_idx", int'(idx_a), 2);
    for (int c = 0; c < 4; c++) tick();
    chk("async_restart_adv", int'(idx_a), 3);

    // Randomized stimulus against the model.
    for (int blk = 0; blk < 60; blk++) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 3) != 0);
      sel  = 3'($urandom_range(0, 7));
      for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
        if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
